vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
Shares one single-port synchronous video RAM between three users: the display scan-out driven by the 640x480 timing generator, a drawing-engine write port, and an internal back-buffer clear engine. The RAM is double-buffered, 320x240 at 8 bpp, and each buffer is scaled 2x to the display. The block sits between the timing generator and the RAM. It also sequences the front/back buffer swap at vertical blanking.

Parameters:
FB_W, 320, framebuffer width in pixels
FB_H, 240, framebuffer height in lines
SCALE_SHIFT, 1, display-to-framebuffer coordinate shift (x>>1, y>>1)
DATA_W, 8, pixel width in bits
FB_ADDR_W, 17, address width within one buffer; must satisfy FB_W*FB_H <= 2**FB_ADDR_W

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous active-high reset
i_pix_stb  in  1  pixel strobe, one clock wide, at most every 2nd clock
i_x  in  10  display x, 0..639
i_y  in  9  display y, 0..479
i_active  in  1  display is in the active pixel region
i_vblank  in  1  one-clock pulse at the start of vertical blanking
i_wr_valid  in  1  drawing-engine write request
i_wr_addr  in  FB_ADDR_W  back-buffer pixel address
i_wr_data  in  DATA_W  write pixel
o_wr_ready  out  1  write accepted this cycle when high together with i_wr_valid
i_clear_req  in  1  pulse: fill the back buffer with i_clear_color
i_clear_color  in  DATA_W  fill value, sampled with i_clear_req
i_swap_req  in  1  pulse: swap buffers at the next eligible vblank
o_swap_done  out  1  one-clock pulse when a swap takes effect
o_front_sel  out  1  index of the buffer currently displayed
o_busy  out  1  clear in progress or swap pending
o_mem_en  out  1  RAM enable
o_mem_we  out  1  RAM write enable
o_mem_addr  out  FB_ADDR_W+1  {buffer select, pixel address}
o_mem_wdata  out  DATA_W  RAM write data
i_mem_rdata  in  DATA_W  RAM read data, valid 1 clock after a read
o_pix_data  out  DATA_W  pixel to DAC, registered
o_pix_valid  out  1  one-clock pulse when o_pix_data is updated

Behaviour:
- Reset: all outputs 0, o_front_sel=0, FSM=IDLE, swap pending cleared, clear counter 0. A reset mid-clear or mid-swap abandons the operation.
- RAM port signals are combinational from the cycle's grant. Only one access per cycle.
- Priority per cycle:
  1. Display read, when i_pix_stb=1.
  2. Clear write, when FSM=CLEAR.
  3. User write.
- o_wr_ready = !i_pix_stb && FSM!=CLEAR && !i_rst. A user write goes to buffer ~o_front_sel.
- Display address, with fx = i_x>>SCALE_SHIFT and fy = i_y>>SCALE_SHIFT:
  - fb_addr = fy*FB_W + fx.
  - For FB_W=320, implement as (fy<<8)+(fy<<6)+fx, with no multiplier.
  - RAM address = {o_front_sel, fb_addr}.
- Display read and output latency, for a strobe at cycle N:
  - At N, the read is issued only if i_active=1.
  - At N+2, o_pix_data = i_mem_rdata captured from N+1, and o_pix_valid=1.
  - If i_active=0 at N, there is no RAM access; o_pix_data=0 (black) at N+2 and o_pix_valid=1.
  - o_pix_data holds between updates.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on i_clear_req: latch color, counter=0.
  - CLEAR: write color to {~o_front_sel, counter} on each cycle not taken by the display, then increment.
  - CLEAR -> IDLE after writing address FB_W*FB_H-1.
  - i_clear_req while in CLEAR is ignored.
- Swap:
  - i_swap_req sets the pending flag; it is idempotent.
  - On i_vblank with pending=1 and FSM=IDLE: toggle o_front_sel, clear pending, and pulse o_swap_done in the same cycle as the toggle.
  - If FSM=CLEAR at vblank, the swap defers to the first vblank after the clear completes.
- Simultaneous events:
  - i_clear_req and i_swap_req in the same cycle: both accepted. The clear runs first; the swap occurs at the first vblank after the clear ends.
  - i_vblank in the same cycle as i_swap_req: the swap happens at this vblank.
- o_busy = (FSM==CLEAR) || pending.

Decomposition:
- Package vga_pkg holds:
  - FB_W, FB_H, FB_SIZE, FB_ADDR_W, DATA_W constants.
  - Enum typedef arb_state_t {IDLE, CLEAR}.
  - Display timing constants (640/480 active), so they are shared with the timing generator.
- One sub-module, vga_fb_addr: combinational (x,y)->fb_addr scaling and stride computation. It is reused by the drawing engine.

Test Plan:
- Strobe with x=3, y=5, i_active=1, front_sel=0 -> at the same cycle o_mem_en=1, we=0, addr=641; at +2 cycles o_pix_data = RAM content at 641 and o_pix_valid=1.
- i_wr_valid held with addr=100, data=0xAB, strobes every 4th clock -> o_wr_ready=0 on strobe cycles only; RAM write to addr 131172 ({1,100}) with data 0xAB.
- i_clear_req with color 0x1F -> exactly 76800 writes of 0x1F to addresses 131072..207871, none on strobe cycles; o_wr_ready=0 throughout; o_busy falls after the last write.
- i_swap_req, then i_vblank 10 cycles later -> o_front_sel 0->1 and o_swap_done pulses in the vblank cycle; subsequent display reads use address bit 17 = 1.
- i_clear_req and i_swap_req together, with a vblank during the clear -> no swap at that vblank; swap at the first vblank after the clear ends.
- Assert i_rst mid-clear -> next cycle FSM=IDLE, o_busy=0, o_front_sel=0, no RAM writes.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA/framebuffer constants and arbiter state type.
// Display timing is shared with the timing generator; framebuffer geometry with the drawing engine.
package vga_pkg;
   localparam int H_ACTIVE    = 640;
   localparam int V_ACTIVE    = 480;
   localparam int X_W         = 10;
   localparam int Y_W         = 9;
   localparam int FB_W        = 320;
   localparam int FB_H        = 240;
   localparam int FB_SIZE     = FB_W * FB_H;
   localparam int FB_ADDR_W   = 17;
   localparam int DATA_W      = 8;
   localparam int SCALE_SHIFT = 1;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } arb_state_t;
endpackage

// File: rtl/vga_fb_addr.sv
// Combinational display (x,y) -> framebuffer pixel address: downscale by SCALE_SHIFT, then y*stride + x.
// Zero latency, no handshake.
module vga_fb_addr #(
   parameter int FB_W        = 320,
   parameter int SCALE_SHIFT = 1,
   parameter int FB_ADDR_W   = 17
) (
   input  logic [9:0]           x_i,
   input  logic [8:0]           y_i,
   output logic [FB_ADDR_W-1:0] fb_addr_o
);
   logic [9:0]           fx;
   logic [8:0]           fy;
   logic [FB_ADDR_W-1:0] fx_w;
   logic [FB_ADDR_W-1:0] fy_w;

   assign fx   = x_i >> SCALE_SHIFT;
   assign fy   = y_i >> SCALE_SHIFT;
   assign fx_w = FB_ADDR_W'(fx);
   assign fy_w = FB_ADDR_W'(fy);

   generate
      if (FB_W == 320) begin : g_stride_320
         // 320 = 256 + 64, so the stride is two shifts and an add.
         assign fb_addr_o = (fy_w << 8) + (fy_w << 6) + fx_w;
      end else begin : g_stride_generic
         assign fb_addr_o = fy_w * FB_ADDR_W'(FB_W) + fx_w;
      end
   endgenerate
endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display read > clear write > user write; pixel out 2 clocks after strobe.
// User writes stall (o_wr_ready low) on strobe cycles and for the whole back-buffer clear.
module vram_arbiter
   import vga_pkg::*;
#(
   parameter int FB_W        = vga_pkg::FB_W,
   parameter int FB_H        = vga_pkg::FB_H,
   parameter int SCALE_SHIFT = vga_pkg::SCALE_SHIFT,
   parameter int DATA_W      = vga_pkg::DATA_W,
   parameter int FB_ADDR_W   = vga_pkg::FB_ADDR_W
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_pix_stb,
   input  logic [9:0]           i_x,
   input  logic [8:0]           i_y,
   input  logic                 i_active,
   input  logic                 i_vblank,
   input  logic                 i_wr_valid,
   input  logic [FB_ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0]    i_wr_data,
   output logic                 o_wr_ready,
   input  logic                 i_clear_req,
   input  logic [DATA_W-1:0]    i_clear_color,
   input  logic                 i_swap_req,
   output logic                 o_swap_done,
   output logic                 o_front_sel,
   output logic                 o_busy,
   output logic                 o_mem_en,
   output logic                 o_mem_we,
   output logic [FB_ADDR_W:0]   o_mem_addr,
   output logic [DATA_W-1:0]    o_mem_wdata,
   input  logic [DATA_W-1:0]    i_mem_rdata,
   output logic [DATA_W-1:0]    o_pix_data,
   output logic                 o_pix_valid
);
   localparam int FB_SIZE_P = FB_W * FB_H;

   arb_state_t           state_q, state_d;
   logic [FB_ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic [DATA_W-1:0]    clr_color_q, clr_color_d;
   logic                 front_q, front_d;
   logic                 pend_q, pend_d;
   logic                 stb_q, act_q;
   logic [DATA_W-1:0]    pix_q, pix_d;
   logic                 pix_vld_q;

   logic [FB_ADDR_W-1:0] disp_addr;
   logic                 rd_gnt, clr_gnt, usr_gnt, swap_fire, clr_last;

   vga_fb_addr #(
      .FB_W        (FB_W),
      .SCALE_SHIFT (SCALE_SHIFT),
      .FB_ADDR_W   (FB_ADDR_W)
   ) u_fb_addr (
      .x_i       (i_x),
      .y_i       (i_y),
      .fb_addr_o (disp_addr)
   );

   always_comb begin
      rd_gnt      = !i_rst && i_pix_stb && i_active;
      clr_gnt     = !i_rst && !i_pix_stb && (state_q == CLEAR);
      o_wr_ready  = !i_rst && !i_pix_stb && (state_q != CLEAR);
      usr_gnt     = i_wr_valid && o_wr_ready;
      clr_last    = (clr_cnt_q == FB_ADDR_W'(FB_SIZE_P - 1));
      // A clear requested this cycle runs before any swap, so it also holds off this vblank.
      swap_fire   = !i_rst && i_vblank && (state_q == IDLE) && !i_clear_req && (pend_q || i_swap_req);

      o_mem_en    = 1'b0;
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      if (rd_gnt) begin
         o_mem_en   = 1'b1;
         o_mem_addr = {front_q, disp_addr};
      end else if (clr_gnt) begin
         o_mem_en    = 1'b1;
         o_mem_we    = 1'b1;
         o_mem_addr  = {~front_q, clr_cnt_q};
         o_mem_wdata = clr_color_q;
      end else if (usr_gnt) begin
         o_mem_en    = 1'b1;
         o_mem_we    = 1'b1;
         o_mem_addr  = {~front_q, i_wr_addr};
         o_mem_wdata = i_wr_data;
      end

      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      clr_color_d = clr_color_q;
      case (state_q)
         IDLE: begin
            if (i_clear_req) begin
               state_d     = CLEAR;
               clr_cnt_d   = '0;
               clr_color_d = i_clear_color;
            end
         end
         CLEAR: begin
            if (clr_gnt) begin
               clr_cnt_d = clr_cnt_q + FB_ADDR_W'(1);
               if (clr_last) begin
                  state_d   = IDLE;
                  clr_cnt_d = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      pend_d  = (pend_q || i_swap_req) && !swap_fire;
      front_d = front_q ^ swap_fire;
      pix_d   = pix_q;
      if (stb_q) begin
         pix_d = act_q ? i_mem_rdata : '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         clr_cnt_q   <= '0;
         clr_color_q <= '0;
         front_q     <= 1'b0;
         pend_q      <= 1'b0;
         stb_q       <= 1'b0;
         act_q       <= 1'b0;
         pix_q       <= '0;
         pix_vld_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         clr_color_q <= clr_color_d;
         front_q     <= front_d;
         pend_q      <= pend_d;
         stb_q       <= i_pix_stb;
         act_q       <= i_active;
         pix_q       <= pix_d;
         pix_vld_q   <= stb_q;
      end
   end

   assign o_swap_done = swap_fire;
   assign o_front_sel = front_q;
   assign o_busy      = (state_q == CLEAR) || pend_q;
   assign o_pix_data  = pix_q;
   assign o_pix_valid = pix_vld_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a per-cycle reference model and a behavioural RAM.
// Framebuffer height is reduced so a full back-buffer clear stays short.
module tb_vram_arbiter;
   localparam int TB_FB_W  = 320;
   localparam int TB_FB_H  = 24;
   localparam int TB_SIZE  = TB_FB_W * TB_FB_H;
   localparam int BUF_BASE = 131072;
   localparam int MEM_N    = 262144;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stb = 1'b0;
   logic [9:0]  x = '0;
   logic [8:0]  y = '0;
   logic        active = 1'b0;
   logic        vblank = 1'b0;
   logic        wr_valid = 1'b0;
   logic [16:0] wr_addr = '0;
   logic [7:0]  wr_data = '0;
   logic        wr_ready;
   logic        clear_req = 1'b0;
   logic [7:0]  clear_color = '0;
   logic        swap_req = 1'b0;
   logic        swap_done, front_sel, busy;
   logic        mem_en, mem_we;
   logic [17:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = '0;
   logic [7:0]  pix_data;
   logic        pix_valid;

   int nchecks = 0;
   int nerr    = 0;
   logic chk_en = 1'b0;

   logic [7:0] ram     [MEM_N];
   logic [7:0] exp_mem [MEM_N];

   vram_arbiter #(
      .FB_W        (TB_FB_W),
      .FB_H        (TB_FB_H),
      .SCALE_SHIFT (1),
      .DATA_W      (8),
      .FB_ADDR_W   (17)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_pix_stb     (stb),
      .i_x           (x),
      .i_y           (y),
      .i_active      (active),
      .i_vblank      (vblank),
      .i_wr_valid    (wr_valid),
      .i_wr_addr     (wr_addr),
      .i_wr_data     (wr_data),
      .o_wr_ready    (wr_ready),
      .i_clear_req   (clear_req),
      .i_clear_color (clear_color),
      .i_swap_req    (swap_req),
      .o_swap_done   (swap_done),
      .o_front_sel   (front_sel),
      .o_busy        (busy),
      .o_mem_en      (mem_en),
      .o_mem_we      (mem_we),
      .o_mem_addr    (mem_addr),
      .o_mem_wdata   (mem_wdata),
      .i_mem_rdata   (mem_rdata),
      .o_pix_data    (pix_data),
      .o_pix_valid   (pix_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] init_val(input int a);
      return 8'(a & 255) ^ 8'h5A;
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      nchecks++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Single-port synchronous RAM seen by the DUT.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   // Reference model state.
   int         m_front = 0, m_pend = 0, m_clearing = 0, m_cnt = 0;
   logic [7:0] m_color = '0, m_pix = '0, p_val = '0;
   int         m_pix_vld = 0, p_stb = 0;

   always @(negedge clk) begin
      int         e_ready, e_en, e_we, e_addr, e_swap;
      logic [7:0] e_wdata, rd_val;
      e_ready = (!stb && !m_clearing && !rst) ? 1 : 0;
      e_en = 0; e_we = 0; e_addr = 0; e_wdata = '0;
      if (!rst) begin
         if (stb && active) begin
            e_en = 1;
            e_addr = m_front * BUF_BASE + (int'(y) / 2) * TB_FB_W + int'(x) / 2;
         end else if (stb) begin
            e_en = 0;
         end else if (m_clearing != 0) begin
            e_en = 1; e_we = 1; e_addr = (1 - m_front) * BUF_BASE + m_cnt; e_wdata = m_color;
         end else if (wr_valid) begin
            e_en = 1; e_we = 1; e_addr = (1 - m_front) * BUF_BASE + int'(wr_addr); e_wdata = wr_data;
         end
      end
      e_swap = (!rst && vblank && !m_clearing && !clear_req && (m_pend != 0 || swap_req)) ? 1 : 0;

      if (chk_en) begin
         check("wr_ready", int'(wr_ready), e_ready);
         check("mem_en", int'(mem_en), e_en);
         if (e_en != 0) begin
            check("mem_we", int'(mem_we), e_we);
            check("mem_addr", int'(mem_addr), e_addr);
            if (e_we != 0) check("mem_wdata", int'(mem_wdata), int'(e_wdata));
         end
         check("swap_done", int'(swap_done), e_swap);
         check("front_sel", int'(front_sel), m_front);
         check("busy", int'(busy), (m_clearing != 0 || m_pend != 0) ? 1 : 0);
         check("pix_valid", int'(pix_valid), m_pix_vld);
         check("pix_data", int'(pix_data), int'(m_pix));
      end

      rd_val = (stb && active) ? exp_mem[e_addr] : 8'h00;
      if (rst) begin
         m_front = 0; m_pend = 0; m_clearing = 0; m_cnt = 0; m_color = '0;
         m_pix = '0; m_pix_vld = 0; p_stb = 0; p_val = '0;
      end else begin
         if (e_we != 0) exp_mem[e_addr] = e_wdata;
         if (p_stb != 0) m_pix = p_val;
         m_pix_vld = p_stb;
         p_stb = stb ? 1 : 0;
         p_val = rd_val;
         if (m_clearing == 0 && clear_req) begin
            m_clearing = 1; m_cnt = 0; m_color = clear_color;
         end else if (m_clearing != 0 && !stb) begin
            m_cnt++;
            if (m_cnt == TB_SIZE) begin
               m_clearing = 0; m_cnt = 0;
            end
         end
         m_pend = ((m_pend != 0 || swap_req) && e_swap == 0) ? 1 : 0;
         if (e_swap != 0) m_front = 1 - m_front;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n_wr, n_rdy, bad, done, i;
      for (int a = 0; a < MEM_N; a++) begin
         ram[a]     = init_val(a);
         exp_mem[a] = init_val(a);
      end
      rst = 1'b1;
      repeat (3) tick();
      chk_en = 1'b1;
      rst = 1'b0;
      #1;
      check("rst_front", int'(front_sel), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_pix_valid", int'(pix_valid), 0);
      check("rst_mem_en", int'(mem_en), 0);

      // Active strobe at (3,5): framebuffer (1,2) -> 2*320+1 = 641.
      tick();
      stb = 1; x = 10'd3; y = 9'd5; active = 1;
      #1;
      check("t1_en", int'(mem_en), 1);
      check("t1_we", int'(mem_we), 0);
      check("t1_addr", int'(mem_addr), 641);
      tick();
      stb = 0;
      tick();
      check("t1_pix_valid", int'(pix_valid), 1);
      check("t1_pix_data", int'(pix_data), 8'hDB);

      // Strobe outside the active region: no access, black pixel.
      stb = 1; active = 0;
      #1;
      check("t1b_en", int'(mem_en), 0);
      tick();
      stb = 0;
      tick();
      check("t1b_pix_valid", int'(pix_valid), 1);
      check("t1b_pix_data", int'(pix_data), 0);

      // User write contending with strobes every 4th clock.
      wr_valid = 1; wr_addr = 17'd100; wr_data = 8'hAB;
      for (int k = 0; k < 16; k++) begin
         stb = (k % 4 == 0); active = 1; x = 10'(k * 8); y = 9'd7;
         #1;
         check("t2_ready", int'(wr_ready), (k % 4 != 0) ? 1 : 0);
         if (k % 4 != 0) begin
            check("t2_addr", int'(mem_addr), 131172);
            check("t2_data", int'(mem_wdata), 8'hAB);
         end
         tick();
      end
      stb = 0; wr_valid = 0;
      tick();

      // Back-buffer clear with a user write held pending and strobes every 4th clock.
      wr_valid = 1; wr_addr = 17'd5; wr_data = 8'h33;
      clear_req = 1; clear_color = 8'h1F;
      tick();
      clear_req = 0;
      n_wr = 0; n_rdy = 0; bad = 0; done = 0;
      for (i = 0; i < 20000 && done == 0; i++) begin
         stb = (i % 4 == 0); active = 1;
         x = 10'((i * 2) % 640); y = 9'((i / 320) % 48);
         #1;
         if (!busy) begin
            done = 1;
         end else begin
            if (mem_en && mem_we) begin
               n_wr++;
               if (int'(mem_addr) < BUF_BASE || int'(mem_addr) > BUF_BASE + TB_SIZE - 1 || mem_wdata != 8'h1F) bad++;
               if (stb) bad++;
            end
            if (wr_ready) n_rdy++;
         end
         tick();
      end
      stb = 0; wr_valid = 0;
      check("t3_done", done, 1);
      check("t3_writes", n_wr, 7680);
      check("t3_bad", bad, 0);
      check("t3_ready_during_clear", n_rdy, 0);
      tick();

      // Swap request, vblank 10 cycles later.
      swap_req = 1;
      tick();
      swap_req = 0;
      repeat (9) tick();
      vblank = 1;
      #1;
      check("t4_swap_done", int'(swap_done), 1);
      check("t4_front_before", int'(front_sel), 0);
      tick();
      vblank = 0;
      #1;
      check("t4_front_after", int'(front_sel), 1);
      check("t4_swap_done_after", int'(swap_done), 0);
      stb = 1; x = 0; y = 0; active = 1;
      #1;
      check("t4_read_addr", int'(mem_addr), 131072);
      tick();
      stb = 0;
      tick();

      // Clear and swap together; vblank during the clear must not swap.
      clear_req = 1; swap_req = 1; clear_color = 8'h44;
      tick();
      clear_req = 0; swap_req = 0;
      repeat (100) tick();
      vblank = 1;
      #1;
      check("t5_no_swap", int'(swap_done), 0);
      check("t5_busy", int'(busy), 1);
      tick();
      vblank = 0;
      for (i = 0; i < 20000 && !wr_ready; i++) tick();
      check("t5_clear_end", int'(wr_ready), 1);
      check("t5_pending", int'(busy), 1);
      check("t5_front_hold", int'(front_sel), 1);
      vblank = 1;
      #1;
      check("t5_swap", int'(swap_done), 1);
      tick();
      vblank = 0;
      #1;
      check("t5_front", int'(front_sel), 0);
      check("t5_idle", int'(busy), 0);

      // Swap request coinciding with vblank fires immediately; then reset mid-clear.
      swap_req = 1; vblank = 1;
      #1;
      check("t6_same_cycle_swap", int'(swap_done), 1);
      tick();
      swap_req = 0; vblank = 0;
      #1;
      check("t6_front", int'(front_sel), 1);
      clear_req = 1; clear_color = 8'h77;
      tick();
      clear_req = 0;
      repeat (50) tick();
      rst = 1;
      tick();
      rst = 0;
      #1;
      check("t6_busy", int'(busy), 0);
      check("t6_front_rst", int'(front_sel), 0);
      check("t6_mem_en", int'(mem_en), 0);
      check("t6_ready", int'(wr_ready), 1);
      tick();
      check("t6_mem_en_later", int'(mem_en), 0);
      repeat (5) tick();

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end
endmodule
